ksz_rx_sequencer: RTL and testbench
===================================

// Module: ksz_rx_sequencer
// PURPOSE
// Receive-side command sequencer for the KSZ8851 Ethernet MAC. It shares the register bus engine with the transmit sequencer.
// On interrupt or poll it checks and acknowledges RXIS, reads the RXQ frame count, then handles each frame in turn:
// reads the frame header, then either drops the frame or DMA-reads it through the data port (Dummy_Read).
// Payload words are delivered on a flow-through stream to the host-side buffer.
// PARAMETERS
// MIN_LEN   12'd64    smallest accepted byte count (incl. 4-byte CRC)
// MAX_LEN   12'd1522  largest accepted byte count (incl. CRC)
// POLL_DIV  20        poll period = 2^POLL_DIV clk40m cycles when irqN is idle
// PORTS
// clk40m        in   1   system clock (one clock domain)
// reset         in   1   asynchronous, active-high reset
// rxEn          in   1   enable; low = finish the current frame, then stay IDLE
// irqN          in   1   KSZ8851 INTRN, active low, already synchronized
// state         in   4   bus engine state: Addr0=0, Read1=4, Read2=5, Write1=7, Write2=8, Wait=9
// readData      in   16  register/data-port read word
// offset        out  8   register address
// length        out  1   1 = 16-bit access
// WR            out  1   1 = write, 0 = read
// writeData     out  16  register write word
// NewCommand    out  1   command request to the bus engine
// Dummy_Read    out  1   1 = each access is an RXQ data-port read
// rxData        out  16  payload word, first byte in [7:0]
// rxValid       out  1   rxData valid, 1 cycle per word; no backpressure
// rxFirst       out  1   with rxValid on the first word of a frame
// rxLast        out  1   with rxValid on the last word of a frame
// rxByteCount   out  12  byte count of the current frame; held until the next header read
// rxDrop        out  1   1-cycle pulse per dropped frame
// frameCount    out  8   accepted frames, wraps at 255
// receiveStatus out  2   00 idle, 01 active, 10 stopping (rxEn low mid-frame)
// BEHAVIOUR
// Reset values: all outputs 0, step=IDLE, poll counter 0. Reset mid-frame abandons the frame; the driver re-inits the MAC.
// Bus handshake:
// - Drive offset/WR/writeData in the Wait, Read2 or Write2 cycle, with NewCommand=1.
// - The Read1 or Write1 cycle completes the command (one tick per access).
// - Read result is sampled in the next Read2 cycle.
// - RMW = a read command, then a write command with writeData = sampled value OR/AND-NOT mask, set at Addr0.
// Steps:
// - IDLE: leave when rxEn and (!irqN or poll counter wrap).
// - ISR_RD: read 0x92. If bit13 is 0, go to IDLE.
// - ISR_ACK: write 0x92 = 0x2000.
// - FCNT: read 0x9C; frames = [15:8]. If 0, go to IDLE.
// - HSTAT: read 0x7C into status.
// - HLEN: read 0x7E; len = [11:0]; rxByteCount <= len.
// - Bad frame: !status[15] | status[0] (CRC) | status[1] (runt) | status[2] (too long) | len < MIN_LEN | len > MAX_LEN.
//   Action: RMW 0x82 set bit0 (RRXEF), pulse rxDrop, go to NEXT.
// - FDPR: write 0x86 = 0x5000.
// - SDA_ON: RMW 0x82 set bit3, then Dummy_Read=1.
// - DATA: R = 3 + ((len+3)&~3)>>1 reads (word0 dummy, words1-2 header, all discarded).
//   The payload word k (k = 1..ceil(len/2)) read is given rxValid=1 the cycle after its Read2 sample.
//   rxLast on k = ceil(len/2). Pad words are read but not emitted. CRC bytes are emitted.
// - SDA_OFF: Dummy_Read=0; RMW 0x82 clear bit3; frameCount++.
// - NEXT: frames--. If frames is nonzero and rxEn, go to HSTAT. Else if rxEn, go to ISR_RD. Else go to IDLE.
// Width rules: word arithmetic is 13-bit, so there is no overflow at MAX_LEN. The frames counter is 8-bit and does not underflow (checked for 0 first).
// irqN asserting mid-sequence is ignored; RXIS is rechecked at NEXT.
// TESTING
// T1: ISR=0x2000, 0x9C=0x0100, status=0x8000, len=64 -> reads 0x92, 0x9C, 0x7C, 0x7E; writes 0x92=0x2000, 0x86=0x5000;
//     0x82 RMW |0x0008; 35 dummy reads; 32 rxValid, rxLast on the 32nd; 0x82 &~0x0008; frameCount=1.
// T2: len=65 -> 37 dummy reads, 33 rxValid, rxLast on the 33rd, rxByteCount=65.
// T3: status=0x8001 (CRC error) -> no 0x86 write, 0x82 RMW |0x0001, one rxDrop pulse, no rxValid.
// T4: 0x9C=0x0300, valid 64/100/1518-byte frames -> 32/50/759 words, frameCount=3, ends with an ISR re-read.
// T5: ISR=0x0000 -> one 0x92 read, no write, back to IDLE with NewCommand=0.
// T6: reset pulse at the 10th data word -> all outputs 0 asynchronously; idle until the next irqN.

Source files
------------

// File: rtl/ksz_rx_sequencer.sv
// ksz_rx_sequencer: KSZ8851 receive command sequencer.
// Drives the shared register bus engine and streams RXQ payload words.
module ksz_rx_sequencer #(
  parameter logic [11:0] MIN_LEN  = 12'd64,
  parameter logic [11:0] MAX_LEN  = 12'd1522,
  parameter int          POLL_DIV = 20
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic        rxEn,
  input  logic        irqN,
  input  logic [3:0]  state,
  input  logic [15:0] readData,
  output logic [7:0]  offset,
  output logic        length,
  output logic        WR,
  output logic [15:0] writeData,
  output logic        NewCommand,
  output logic        Dummy_Read,
  output logic [15:0] rxData,
  output logic        rxValid,
  output logic        rxFirst,
  output logic        rxLast,
  output logic [11:0] rxByteCount,
  output logic        rxDrop,
  output logic [7:0]  frameCount,
  output logic [1:0]  receiveStatus
);

  localparam logic [3:0] B_ADDR0  = 4'd0;
  localparam logic [3:0] B_READ1  = 4'd4;
  localparam logic [3:0] B_READ2  = 4'd5;
  localparam logic [3:0] B_WRITE1 = 4'd7;
  localparam logic [3:0] B_WRITE2 = 4'd8;
  localparam logic [3:0] B_WAIT   = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE, S_ISR_RD, S_ISR_ACK, S_FCNT, S_HSTAT,
    S_HLEN, S_DROP_RD, S_DROP_WR, S_FDPR, S_SDA_RD,
    S_SDA_WR, S_DATA, S_OFF_RD, S_OFF_WR, S_NEXT
  } step_t;

  typedef enum logic [1:0] {
    P_ISSUE, P_BUSY, P_SAMPLE
  } phase_t;

  step_t  step_q, step_d;
  phase_t phase_q, phase_d;

  logic [POLL_DIV-1:0] poll_q;
  logic [7:0]  frames_q;
  logic [15:0] status_q;
  logic [15:0] rdata_q;
  logic [15:0] rmw_q;
  logic [12:0] cnt_q;

  logic        acc;
  logic        is_wr;
  logic        rmw_wr;
  logic        accept;
  logic        done;
  logic        bad;
  logic [7:0]  off;
  logic [15:0] rmw_val;
  logic [11:0] len_in;
  logic [12:0] len13;
  logic [12:0] rlast;
  logic [12:0] wlast;

  // last read index of the DMA and last payload word index
  assign len13 = {1'b0, rxByteCount};
  assign rlast = 13'd2 + (((len13 + 13'd3) & 13'h1ffc) >> 1);
  assign wlast = ((len13 + 13'd1) >> 1) + 13'd2;
  assign len_in = readData[11:0];

  assign bad = !status_q[15] | status_q[0] | status_q[1]
             | status_q[2] | (len_in < MIN_LEN)
             | (len_in > MAX_LEN);

  always_comb begin
    step_d  = step_q;
    phase_d = phase_q;
    acc     = (step_q != S_IDLE) && (step_q != S_NEXT);
    is_wr   = 1'b0;
    rmw_wr  = 1'b0;
    off     = 8'h00;
    rmw_val = rdata_q;
    unique case (step_q)
      S_ISR_RD:  off = 8'h92;
      S_ISR_ACK: begin off = 8'h92; is_wr = 1'b1; end
      S_FCNT:    off = 8'h9c;
      S_HSTAT:   off = 8'h7c;
      S_HLEN:    off = 8'h7e;
      S_DROP_RD: off = 8'h82;
      S_DROP_WR: begin
        off = 8'h82; is_wr = 1'b1; rmw_wr = 1'b1;
        rmw_val = rdata_q | 16'h0001;
      end
      S_FDPR:    begin off = 8'h86; is_wr = 1'b1; end
      S_SDA_RD:  off = 8'h82;
      S_SDA_WR:  begin
        off = 8'h82; is_wr = 1'b1; rmw_wr = 1'b1;
        rmw_val = rdata_q | 16'h0008;
      end
      S_OFF_RD:  off = 8'h82;
      S_OFF_WR:  begin
        off = 8'h82; is_wr = 1'b1; rmw_wr = 1'b1;
        rmw_val = rdata_q & ~16'h0008;
      end
      default:   off = 8'h00;
    endcase

    accept = acc && (phase_q == P_ISSUE)
           && ((state == B_WAIT) || (state == B_READ2)
           || (state == B_WRITE2));
    done = acc
         && (((phase_q == P_BUSY) && is_wr && (state == B_WRITE1))
         || ((phase_q == P_SAMPLE) && (state == B_READ2)));

    if (accept) phase_d = P_BUSY;
    if ((phase_q == P_BUSY) && !is_wr && (state == B_READ1))
      phase_d = P_SAMPLE;
    if (done) phase_d = P_ISSUE;

    unique case (step_q)
      S_IDLE:
        if (rxEn && (!irqN || (&poll_q))) step_d = S_ISR_RD;
      S_ISR_RD:
        if (done) step_d = readData[13] ? S_ISR_ACK : S_IDLE;
      S_ISR_ACK: if (done) step_d = S_FCNT;
      S_FCNT:
        if (done)
          step_d = (readData[15:8] == 8'd0) ? S_IDLE : S_HSTAT;
      S_HSTAT:   if (done) step_d = S_HLEN;
      S_HLEN:    if (done) step_d = bad ? S_DROP_RD : S_FDPR;
      S_DROP_RD: if (done) step_d = S_DROP_WR;
      S_DROP_WR: if (done) step_d = S_NEXT;
      S_FDPR:    if (done) step_d = S_SDA_RD;
      S_SDA_RD:  if (done) step_d = S_SDA_WR;
      S_SDA_WR:  if (done) step_d = S_DATA;
      S_DATA:    if (done && (cnt_q == rlast)) step_d = S_OFF_RD;
      S_OFF_RD:  if (done) step_d = S_OFF_WR;
      S_OFF_WR:  if (done) step_d = S_NEXT;
      S_NEXT: begin
        if ((frames_q > 8'd1) && rxEn) step_d = S_HSTAT;
        else if (rxEn) step_d = S_ISR_RD;
        else step_d = S_IDLE;
      end
      default:   step_d = S_IDLE;
    endcase
  end

  assign NewCommand = accept;
  assign length     = acc;
  assign WR         = acc && is_wr;
  assign offset     = off;
  assign writeData  = !(acc && is_wr) ? 16'h0000
                    : rmw_wr ? rmw_q
                    : (step_q == S_ISR_ACK) ? 16'h2000
                    : 16'h5000;

  assign receiveStatus = (step_q == S_IDLE) ? 2'b00
                       : rxEn ? 2'b01 : 2'b10;

  always_ff @(posedge clk40m or posedge reset) begin
    if (reset) begin
      step_q      <= S_IDLE;
      phase_q     <= P_ISSUE;
      poll_q      <= '0;
      frames_q    <= 8'd0;
      status_q    <= 16'h0000;
      rdata_q     <= 16'h0000;
      rmw_q       <= 16'h0000;
      cnt_q       <= 13'd0;
      Dummy_Read  <= 1'b0;
      rxData      <= 16'h0000;
      rxValid     <= 1'b0;
      rxFirst     <= 1'b0;
      rxLast      <= 1'b0;
      rxByteCount <= 12'd0;
      rxDrop      <= 1'b0;
      frameCount  <= 8'd0;
    end else begin
      step_q  <= step_d;
      phase_q <= phase_d;
      rxValid <= 1'b0;
      rxFirst <= 1'b0;
      rxLast  <= 1'b0;
      rxDrop  <= 1'b0;
      if ((step_q == S_IDLE) && (step_d == S_IDLE))
        poll_q <= poll_q + 1'b1;
      else
        poll_q <= '0;
      if (done && !is_wr) rdata_q <= readData;
      // the RMW write value is formed once the write reaches Addr0
      if ((phase_q == P_BUSY) && rmw_wr && (state == B_ADDR0))
        rmw_q <= rmw_val;
      if (done && (step_q == S_FCNT)) frames_q <= readData[15:8];
      if (done && (step_q == S_HSTAT)) status_q <= readData;
      if (done && (step_q == S_HLEN)) rxByteCount <= len_in;
      if (done && (step_q == S_DROP_WR)) rxDrop <= 1'b1;
      if (done && (step_q == S_SDA_WR)) begin
        Dummy_Read <= 1'b1;
        cnt_q      <= 13'd0;
      end
      if (done && (step_q == S_DATA)) begin
        cnt_q <= cnt_q + 13'd1;
        if (cnt_q == rlast) Dummy_Read <= 1'b0;
        if ((cnt_q >= 13'd3) && (cnt_q <= wlast)) begin
          rxValid <= 1'b1;
          rxData  <= readData;
          rxFirst <= (cnt_q == 13'd3);
          rxLast  <= (cnt_q == wlast);
        end
      end
      if (done && (step_q == S_OFF_WR)) frameCount <= frameCount + 8'd1;
      if ((step_q == S_NEXT) && (frames_q != 8'd0))
        frames_q <= frames_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_ksz_rx_sequencer.sv
// tb_ksz_rx_sequencer: directed bench with a bus engine and KSZ8851 model.
// Expected values are hand-derived per scenario.
module tb_ksz_rx_sequencer;

  logic        clk40m = 1'b0;
  logic        reset  = 1'b1;
  logic        rxEn   = 1'b1;
  logic        irqN   = 1'b1;
  logic [3:0]  state;
  logic [15:0] readData;
  logic [7:0]  offset;
  logic        length;
  logic        WR;
  logic [15:0] writeData;
  logic        NewCommand;
  logic        Dummy_Read;
  logic [15:0] rxData;
  logic        rxValid;
  logic        rxFirst;
  logic        rxLast;
  logic [11:0] rxByteCount;
  logic        rxDrop;
  logic [7:0]  frameCount;
  logic [1:0]  receiveStatus;

  ksz_rx_sequencer dut (
    .clk40m(clk40m), .reset(reset), .rxEn(rxEn), .irqN(irqN),
    .state(state), .readData(readData), .offset(offset),
    .length(length), .WR(WR), .writeData(writeData),
    .NewCommand(NewCommand), .Dummy_Read(Dummy_Read),
    .rxData(rxData), .rxValid(rxValid), .rxFirst(rxFirst),
    .rxLast(rxLast), .rxByteCount(rxByteCount), .rxDrop(rxDrop),
    .frameCount(frameCount), .receiveStatus(receiveStatus)
  );

  always #12 clk40m = ~clk40m;

  int n_tests = 0;
  int n_fail  = 0;

  // MAC register model
  logic [15:0] m_isr, m_fcnt, m_clr, m_r82;
  logic [15:0] m_st[$];
  logic [11:0] m_len[$];
  int          m_di;
  logic [7:0]  c_off;
  logic        c_wr, c_dummy;

  // observed traffic
  logic [7:0]  rd_q[$];
  logic [23:0] wr_q[$];
  int          last_q[$];
  int n_dummy, n_valid, n_first, n_drop, bad_words, k;

  function automatic logic [15:0] word(int di);
    logic [7:0] b;
    b = di[7:0];
    return {~b, b};
  endfunction

  function automatic logic [15:0] m_read();
    if (c_dummy) return word(m_di);
    case (c_off)
      8'h92:   return m_isr & ~m_clr;
      8'h9c:   return m_fcnt;
      8'h7c:   return (m_st.size() > 0) ? m_st[0] : 16'h0;
      8'h7e:   return (m_len.size() > 0) ? {4'h0, m_len[0]} : 16'h0;
      8'h82:   return m_r82;
      default: return 16'h0;
    endcase
  endfunction

  // bus engine: Wait/Read2/Write2 -> Addr0 -> Read1/Write1 -> Read2/Write2
  always @(posedge clk40m or posedge reset) begin
    if (reset) begin
      state    <= 4'd9;
      readData <= 16'h0;
      m_clr    <= 16'h0;
      m_r82    <= 16'h0;
      m_di     <= 0;
      c_off    <= 8'h0;
      c_wr     <= 1'b0;
      c_dummy  <= 1'b0;
    end else begin
      case (state)
        4'd9, 4'd5, 4'd8:
          if (NewCommand) begin
            c_off   <= offset;
            c_wr    <= WR;
            c_dummy <= Dummy_Read;
            state   <= 4'd0;
          end else begin
            state <= 4'd9;
          end
        4'd0: state <= c_wr ? 4'd7 : 4'd4;
        4'd4: begin
          readData <= m_read();
          if (c_dummy) m_di <= m_di + 1;
          state <= 4'd5;
        end
        4'd7: begin
          if (c_off == 8'h92) m_clr <= m_clr | writeData;
          if (c_off == 8'h82) begin
            if ((writeData[0] || (m_r82[3] && !writeData[3]))
                && (m_st.size() > 0)) begin
              void'(m_st.pop_front());
              void'(m_len.pop_front());
            end
            if (writeData[3]) m_di <= 0;
            m_r82 <= writeData & ~16'h0001;
          end
          state <= 4'd8;
        end
        default: state <= 4'd9;
      endcase
    end
  end

  always @(negedge clk40m) begin
    if (reset) begin
      rd_q.delete();
      wr_q.delete();
      last_q.delete();
      n_dummy   <= 0;
      n_valid   <= 0;
      n_first   <= 0;
      n_drop    <= 0;
      bad_words <= 0;
      k         <= 0;
    end else begin
      if (NewCommand && ((state == 4'd9) || (state == 4'd5)
          || (state == 4'd8))) begin
        if (Dummy_Read) n_dummy <= n_dummy + 1;
        else if (!WR) rd_q.push_back(offset);
      end
      if (state == 4'd7) wr_q.push_back({c_off, writeData});
      if (rxValid) begin
        n_valid <= n_valid + 1;
        k <= rxFirst ? 1 : k + 1;
        if (rxData !== word(rxFirst ? 3 : k + 3))
          bad_words <= bad_words + 1;
        if (rxFirst) n_first <= n_first + 1;
        if (rxLast) last_q.push_back(rxFirst ? 1 : k + 1);
      end
      if (rxDrop) n_drop <= n_drop + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd_pack(int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v = {v[55:0], (i < rd_q.size()) ? rd_q[i] : 8'hff};
    return v;
  endfunction

  function automatic logic [63:0] wr_pack(int a, int n);
    logic [63:0] v;
    v = '0;
    for (int i = a; i < a + n; i++)
      v = {v[39:0], (i < wr_q.size()) ? wr_q[i] : 24'hffffff};
    return v;
  endfunction

  function automatic logic [63:0] last_pack();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < last_q.size(); i++)
      v = {v[47:0], last_q[i][15:0]};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk40m);
    reset = 1'b1;
    irqN  = 1'b1;
    m_st.delete();
    m_len.delete();
    repeat (2) @(negedge clk40m);
    reset = 1'b0;
    @(negedge clk40m);
  endtask

  task automatic add_frame(input logic [15:0] st, input logic [11:0] len);
    m_st.push_back(st);
    m_len.push_back(len);
  endtask

  task automatic run_irq(input string tag);
    int t;
    @(negedge clk40m);
    irqN = 1'b0;
    @(negedge clk40m);
    irqN = 1'b1;
    t = 0;
    while ((receiveStatus != 2'b00) && (t < 20000)) begin
      @(negedge clk40m);
      t++;
    end
    check(tag, t < 20000, 1'b1);
    repeat (2) @(negedge clk40m);
  endtask

  initial begin
    int t;
    m_isr  = 16'h0;
    m_fcnt = 16'h0;

    do_reset();
    check("rst_outs_a", {offset, length, WR, writeData, NewCommand,
          Dummy_Read, receiveStatus, frameCount}, '0);
    check("rst_outs_b", {rxData, rxValid, rxFirst, rxLast,
          rxByteCount, rxDrop}, '0);

    // T1: one 64-byte frame
    do_reset();
    m_isr = 16'h2000; m_fcnt = 16'h0100;
    add_frame(16'h8000, 12'd64);
    run_irq("t1_done");
    check("t1_reads", rd_pack(7), 64'h929c7c7e828292);
    check("t1_nreads", rd_q.size(), 7);
    check("t1_wr01", wr_pack(0, 2), 64'h922000865000);
    check("t1_wr23", wr_pack(2, 2), 64'h820008820000);
    check("t1_dummy", n_dummy, 35);
    check("t1_valid", n_valid, 32);
    check("t1_last", last_pack(), 32);
    check("t1_first", n_first, 1);
    check("t1_data", bad_words, 0);
    check("t1_fcount", frameCount, 1);

    // T2: odd length
    do_reset();
    m_isr = 16'h2000; m_fcnt = 16'h0100;
    add_frame(16'h8000, 12'd65);
    run_irq("t2_done");
    check("t2_dummy", n_dummy, 37);
    check("t2_valid", n_valid, 33);
    check("t2_last", last_pack(), 33);
    check("t2_bytes", rxByteCount, 65);
    check("t2_data", bad_words, 0);

    // T3: CRC error frame dropped
    do_reset();
    m_isr = 16'h2000; m_fcnt = 16'h0100;
    add_frame(16'h8001, 12'd64);
    run_irq("t3_done");
    check("t3_reads", rd_pack(6), 64'h929c7c7e8292);
    check("t3_nwr", wr_q.size(), 2);
    check("t3_wr", wr_pack(0, 2), 64'h922000820001);
    check("t3_drop", n_drop, 1);
    check("t3_valid", n_valid, 0);
    check("t3_fcount", frameCount, 0);

    // T4: three frames in one batch
    do_reset();
    m_isr = 16'h2000; m_fcnt = 16'h0300;
    add_frame(16'h8000, 12'd64);
    add_frame(16'h8000, 12'd100);
    add_frame(16'h8000, 12'd1518);
    run_irq("t4_done");
    check("t4_valid", n_valid, 841);
    check("t4_dummy", n_dummy, 851);
    check("t4_lasts", last_pack(), 64'h0020003202f7);
    check("t4_fcount", frameCount, 3);
    check("t4_endisr", (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 8'h0,
          8'h92);
    check("t4_data", bad_words, 0);

    // T5: no RXIS
    do_reset();
    m_isr = 16'h0000;
    run_irq("t5_done");
    check("t5_reads", rd_pack(1), 8'h92);
    check("t5_nreads", rd_q.size(), 1);
    check("t5_nwr", wr_q.size(), 0);
    check("t5_cmd", NewCommand, 1'b0);

    // T6: asynchronous reset mid-frame
    do_reset();
    m_isr = 16'h2000; m_fcnt = 16'h0100;
    add_frame(16'h8000, 12'd64);
    @(negedge clk40m);
    irqN = 1'b0;
    @(negedge clk40m);
    irqN = 1'b1;
    t = 0;
    while ((n_valid < 10) && (t < 5000)) begin
      @(negedge clk40m);
      t++;
    end
    check("t6_reach", n_valid, 10);
    #3 reset = 1'b1;
    #1;
    check("t6_async_a", {offset, length, WR, writeData, NewCommand,
          Dummy_Read, receiveStatus, frameCount}, '0);
    check("t6_async_b", {rxData, rxValid, rxFirst, rxLast,
          rxByteCount, rxDrop}, '0);
    m_isr = 16'h0000;
    m_st.delete();
    m_len.delete();
    repeat (2) @(negedge clk40m);
    reset = 1'b0;
    repeat (200) @(negedge clk40m);
    check("t6_quiet", rd_q.size() + n_dummy + wr_q.size(), 0);
    run_irq("t6_done");
    check("t6_reads", rd_pack(1), 8'h92);
    check("t6_nreads", rd_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
